arbitro_somador_sinal: RTL and testbench

- Shares one mixed-signedness 8-bit adder datapath between N_REQ requesters.
- Each requester submits an operation packet: two signed operands, two unsigned operands and a 2-bit opcode `codigo`.
- Requests are granted round-robin, computed in a registered stage, and returned with the requester id on a valid/ready output channel.
- Sits between requester blocks and the result consumer; also counts completed operations.

---
 rtl/arbitro_somador_sinal.sv | 207 ++++++++++++++++++++
 tb/tb_arbitro_somador_sinal.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_somador_sinal.sv
// Round-robin arbiter sharing one mixed-signedness 8-bit adder between N_REQ requesters.
// Optional overflow/carry output `flag_estouro` is enabled by defining ARBITRO_SOMADOR_FLAG_EN.
module arbitro_somador_sinal #(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*8-1:0]   req_signed_1,
  input  logic [N_REQ*4-1:0]   req_signed_2,
  input  logic [N_REQ*8-1:0]   req_unsigned_1,
  input  logic [N_REQ*4-1:0]   req_unsigned_2,
  input  logic [N_REQ*2-1:0]   req_codigo,
  output logic [7:0]           saida,
  output logic [ID_W-1:0]      saida_id,
  output logic                 saida_valid,
  input  logic                 saida_ready,
  output logic                 ocupado,
  output logic [CNT_W-1:0]     contador_ops,
`ifdef ARBITRO_SOMADOR_FLAG_EN
  output logic                 flag_estouro,
`endif
  output logic [1:0]           estado
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // Producers keep data stable while valid is high and not yet accepted; req_ready is
  // combinational (grant) and saida_valid is registered and held until accepted.

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    ENTREGA = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt;
  logic            found;
  logic            accept;

  logic [7:0]      sel_s1, sel_u1;
  logic [3:0]      sel_s2, sel_u2;
  logic [1:0]      sel_cod;

  logic [7:0]      lat_s1, lat_u1;
  logic [3:0]      lat_s2, lat_u2;
  logic [1:0]      lat_cod;
  logic [ID_W-1:0] lat_id;

  logic [7:0]      op_a, op_b;
  logic [7:0]      resultado;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned off);
    int unsigned t;
    t = 32'(base) + off;
    if (t >= N_REQ) t = t - N_REQ;
    return t[ID_W-1:0];
  endfunction

  // Round-robin search starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[wrap_add(ptr, i)]) begin
        found = 1'b1;
        gnt   = wrap_add(ptr, i);
      end
    end
  end

  assign accept = (state_q == OCIOSO) && found && !rst;

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      req_ready[k] = accept && (gnt == ID_W'(k));
    end
  end

  always_comb begin
    sel_s1  = '0;
    sel_s2  = '0;
    sel_u1  = '0;
    sel_u2  = '0;
    sel_cod = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt == ID_W'(k)) begin
        sel_s1  = req_signed_1[k*8 +: 8];
        sel_s2  = req_signed_2[k*4 +: 4];
        sel_u1  = req_unsigned_1[k*8 +: 8];
        sel_u2  = req_unsigned_2[k*4 +: 4];
        sel_cod = req_codigo[k*2 +: 2];
      end
    end
  end

  // Opcode 11 mixes signedness, so signed_2 is zero-extended there.
  always_comb begin
    op_a = lat_u1;
    op_b = {4'b0000, lat_u2};
    case (lat_cod)
      2'b00: begin
        op_a = lat_s1;
        op_b = {{4{lat_s2[3]}}, lat_s2};
      end
      2'b01: begin
        op_a = lat_u1;
        op_b = {4'b0000, lat_u2};
      end
      2'b10: begin
        op_a = lat_u1;
        op_b = lat_s1;
      end
      default: begin
        op_a = lat_u1;
        op_b = {4'b0000, lat_s2};
      end
    endcase
  end

`ifdef ARBITRO_SOMADOR_FLAG_EN
  logic [8:0] soma;
  logic       flag_d;

  always_comb begin
    soma      = {1'b0, op_a} + {1'b0, op_b};
    resultado = soma[7:0];
    if (lat_cod == 2'b00) begin
      flag_d = (op_a[7] == op_b[7]) && (soma[7] != op_a[7]);
    end else begin
      flag_d = soma[8];
    end
  end
`else
  assign resultado = op_a + op_b;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCIOSO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO:  if (found) state_d = CALCULA;
      CALCULA: state_d = ENTREGA;
      ENTREGA: if (saida_valid && saida_ready) state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      saida        <= '0;
      saida_id     <= '0;
      saida_valid  <= 1'b0;
      contador_ops <= '0;
      lat_s1       <= '0;
      lat_s2       <= '0;
      lat_u1       <= '0;
      lat_u2       <= '0;
      lat_cod      <= '0;
      lat_id       <= '0;
`ifdef ARBITRO_SOMADOR_FLAG_EN
      flag_estouro <= 1'b0;
`endif
    end else begin
      if (accept) begin
        lat_s1  <= sel_s1;
        lat_s2  <= sel_s2;
        lat_u1  <= sel_u1;
        lat_u2  <= sel_u2;
        lat_cod <= sel_cod;
        lat_id  <= gnt;
      end
      if (state_q == CALCULA) begin
        saida       <= resultado;
        saida_id    <= lat_id;
        saida_valid <= 1'b1;
`ifdef ARBITRO_SOMADOR_FLAG_EN
        flag_estouro <= flag_d;
`endif
      end
      if ((state_q == ENTREGA) && saida_valid && saida_ready) begin
        saida_valid  <= 1'b0;
        ptr          <= wrap_add(lat_id, 1);
        contador_ops <= contador_ops + 1'b1;
      end
    end
  end

  assign ocupado = (state_q != OCIOSO);
  assign estado  = state_q;

endmodule

// File: tb/tb_arbitro_somador_sinal.sv
// Directed self-checking bench for arbitro_somador_sinal with N_REQ=2.
// Define ARBITRO_SOMADOR_FLAG_EN to also check flag_estouro.
module tb_arbitro_somador_sinal;

  localparam int N_REQ = 2;
  localparam int ID_W  = 1;
  localparam int CNT_W = 16;

  logic                 clk;
  logic                 rst;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*8-1:0]   req_signed_1;
  logic [N_REQ*4-1:0]   req_signed_2;
  logic [N_REQ*8-1:0]   req_unsigned_1;
  logic [N_REQ*4-1:0]   req_unsigned_2;
  logic [N_REQ*2-1:0]   req_codigo;
  logic [7:0]           saida;
  logic [ID_W-1:0]      saida_id;
  logic                 saida_valid;
  logic                 saida_ready;
  logic                 ocupado;
  logic [CNT_W-1:0]     contador_ops;
  logic [1:0]           estado;
`ifdef ARBITRO_SOMADOR_FLAG_EN
  logic                 flag_estouro;
`endif

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  logic [7:0]       exp_q[$];
  logic [ID_W-1:0]  exp_id_q[$];
  logic [N_REQ-1:0] exp_grant_q[$];

  arbitro_somador_sinal #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_signed_1   (req_signed_1),
    .req_signed_2   (req_signed_2),
    .req_unsigned_1 (req_unsigned_1),
    .req_unsigned_2 (req_unsigned_2),
    .req_codigo     (req_codigo),
    .saida          (saida),
    .saida_id       (saida_id),
    .saida_valid    (saida_valid),
    .saida_ready    (saida_ready),
    .ocupado        (ocupado),
    .contador_ops   (contador_ops),
`ifdef ARBITRO_SOMADOR_FLAG_EN
    .flag_estouro   (flag_estouro),
`endif
    .estado         (estado)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver
  task automatic drive_req(input int k, input logic [1:0] cod, input logic [7:0] s1,
                           input logic [3:0] s2, input logic [7:0] u1, input logic [3:0] u2);
    req_signed_1[k*8 +: 8]   = s1;
    req_signed_2[k*4 +: 4]   = s2;
    req_unsigned_1[k*8 +: 8] = u1;
    req_unsigned_2[k*4 +: 4] = u2;
    req_codigo[k*2 +: 2]     = cod;
    req_valid[k]             = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    saida_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if (saida !== 8'h00) begin errors++; $display("FAIL reset_saida: got %h expected 00", saida); end
    checks++; if (saida_valid !== 1'b0) begin errors++; $display("FAIL reset_saida_valid: got %b expected 0", saida_valid); end
    checks++; if (saida_id !== 1'b0) begin errors++; $display("FAIL reset_saida_id: got %h expected 0", saida_id); end
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado: got %b expected 0", ocupado); end
    checks++; if (contador_ops !== 16'd0) begin errors++; $display("FAIL reset_contador: got %0d expected 0", contador_ops); end
`ifdef ARBITRO_SOMADOR_FLAG_EN
    checks++; if (flag_estouro !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b expected 0", flag_estouro); end
`endif
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // One full operation on requester k: grant, CALCULA, result 2 cycles later, handshake.
  task automatic test_op(input string tag, input int k, input logic [1:0] cod,
                         input logic [7:0] s1, input logic [3:0] s2, input logic [7:0] u1,
                         input logic [3:0] u2, input logic [7:0] exp_s, input logic exp_f);
    logic [N_REQ-1:0] exp_rdy;
    exp_rdy = '0;
    exp_rdy[k] = 1'b1;
    drive_req(k, cod, s1, s2, u1, u2);
    #1;
    checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL %s_grant: got %b expected %b", tag, req_ready, exp_rdy); end
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    checks++; if (saida_valid !== 1'b0 || ocupado !== 1'b1 || req_ready !== 2'b00) begin
      errors++; $display("FAIL %s_calcula: got valid=%b ocupado=%b ready=%b expected 0 1 00", tag, saida_valid, ocupado, req_ready);
    end
    @(posedge clk);
    #1;
    checks++; if (saida_valid !== 1'b1) begin errors++; $display("FAIL %s_latency: got valid=%b expected 1", tag, saida_valid); end
    checks++; if (saida !== exp_s) begin errors++; $display("FAIL %s_saida: got %h expected %h", tag, saida, exp_s); end
    checks++; if (saida_id !== ID_W'(k)) begin errors++; $display("FAIL %s_id: got %0d expected %0d", tag, saida_id, k); end
`ifdef ARBITRO_SOMADOR_FLAG_EN
    checks++; if (flag_estouro !== exp_f) begin errors++; $display("FAIL %s_flag: got %b expected %b", tag, flag_estouro, exp_f); end
`else
    if (exp_f === 1'bx) $display("note: %s has unknown flag expectation", tag);
`endif
    saida_ready = 1'b1;
    @(posedge clk);
    #1;
    saida_ready = 1'b0;
    exp_cnt++;
    checks++; if (saida_valid !== 1'b0 || ocupado !== 1'b0) begin
      errors++; $display("FAIL %s_handshake: got valid=%b ocupado=%b expected 0 0", tag, saida_valid, ocupado);
    end
    checks++; if (contador_ops !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL %s_contador: got %0d expected %0d", tag, contador_ops, exp_cnt); end
  endtask

  task automatic test_arith();
    test_op("c00_neg",   0, 2'b00, 8'hF6, 4'h3, 8'h00, 4'h0, 8'hF9, 1'b0);
    test_op("c01_wrap",  1, 2'b01, 8'h00, 4'h0, 8'hFF, 4'h2, 8'h01, 1'b1);
    test_op("c10_raw",   0, 2'b10, 8'h80, 4'h0, 8'h80, 4'h0, 8'h00, 1'b1);
    test_op("c11_zext",  1, 2'b11, 8'h00, 4'hF, 8'h10, 4'h0, 8'h1F, 1'b0);
    test_op("c00_sext",  0, 2'b00, 8'h05, 4'hE, 8'h00, 4'h0, 8'h03, 1'b0);
    test_op("c00_novf",  1, 2'b00, 8'h80, 4'h8, 8'h00, 4'h0, 8'h78, 1'b1);
    test_op("c00_povf",  0, 2'b00, 8'h7F, 4'h1, 8'h00, 4'h0, 8'h80, 1'b1);
    test_op("c01_carry", 1, 2'b01, 8'h00, 4'h0, 8'hFF, 4'h1, 8'h00, 1'b1);
  endtask

  task automatic test_back_to_back();
    int got;
    logic [N_REQ-1:0] eg;
    logic [7:0] es;
    logic [ID_W-1:0] eid;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      exp_grant_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
      exp_q.push_back((i % 2 == 0) ? 8'h11 : 8'h22);
      exp_id_q.push_back((i % 2 == 0) ? 1'b0 : 1'b1);
    end
    drive_req(0, 2'b01, 8'h00, 4'h0, 8'h10, 4'h1);
    drive_req(1, 2'b01, 8'h00, 4'h0, 8'h20, 4'h2);
    saida_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      #1;
      checks++; if ($countones(req_ready) > 1) begin errors++; $display("FAIL b2b_onehot: got %b expected at most one bit", req_ready); end
      if (req_ready !== 2'b00) begin
        checks++;
        if (exp_grant_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_grant: got %b expected 00", req_ready);
        end else begin
          eg = exp_grant_q.pop_front();
          if (req_ready !== eg) begin errors++; $display("FAIL b2b_grant: got %b expected %b", req_ready, eg); end
        end
      end
      if (saida_valid === 1'b1) begin
        es = exp_q.pop_front();
        eid = exp_id_q.pop_front();
        checks++; if (saida !== es) begin errors++; $display("FAIL b2b_saida: got %h expected %h", saida, es); end
        checks++; if (saida_id !== eid) begin errors++; $display("FAIL b2b_id: got %0d expected %0d", saida_id, eid); end
        got++;
        exp_cnt++;
        if (got == 4) req_valid = '0;
      end
      @(posedge clk);
      #1;
    end
    checks++; if (got != 4) begin errors++; $display("FAIL b2b_timeout: got %0d results expected 4", got); end
    checks++; if (contador_ops !== 16'd4) begin errors++; $display("FAIL b2b_contador: got %0d expected 4", contador_ops); end
    saida_ready = 1'b0;
    req_valid = '0;
    exp_grant_q.delete();
    exp_q.delete();
    exp_id_q.delete();
  endtask

  task automatic test_stall();
    drive_req(0, 2'b00, 8'h12, 4'h4, 8'h00, 4'h0);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_grant: got %b expected 01", req_ready); end
    @(posedge clk);
    #1;
    req_valid = '0;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (saida !== 8'h16 || saida_id !== 1'b0 || saida_valid !== 1'b1 || req_ready !== 2'b00 ||
          contador_ops !== CNT_W'(exp_cnt)) begin
        errors++;
        $display("FAIL stall_hold: got saida=%h id=%0d valid=%b ready=%b cnt=%0d expected 16 0 1 00 %0d",
                 saida, saida_id, saida_valid, req_ready, contador_ops, exp_cnt);
      end
    end
    req_valid = '0;
    saida_ready = 1'b1;
    @(posedge clk);
    #1;
    saida_ready = 1'b0;
    exp_cnt++;
    checks++; if (saida_valid !== 1'b0 || contador_ops !== CNT_W'(exp_cnt)) begin
      errors++; $display("FAIL stall_release: got valid=%b cnt=%0d expected 0 %0d", saida_valid, contador_ops, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    drive_req(0, 2'b01, 8'h00, 4'h0, 8'h44, 4'h1);
    drive_req(1, 2'b01, 8'h00, 4'h0, 8'h33, 4'h1);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rmid_ptr_grant: got %b expected 10", req_ready); end
    @(posedge clk);
    #1;
    checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL rmid_calcula: got ocupado=%b expected 1", ocupado); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rmid_ready_in_reset: got %b expected 00", req_ready); end
    checks++; if (saida_valid !== 1'b0 || saida !== 8'h00 || saida_id !== 1'b0) begin
      errors++; $display("FAIL rmid_outputs: got valid=%b saida=%h id=%0d expected 0 00 0", saida_valid, saida, saida_id);
    end
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL rmid_ocupado: got %b expected 0", ocupado); end
    checks++; if (contador_ops !== 16'd0) begin errors++; $display("FAIL rmid_contador: got %0d expected 0", contador_ops); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_ptr_reset: got %b expected 01", req_ready); end
    req_valid = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_signed_1 = '0;
    req_signed_2 = '0;
    req_unsigned_1 = '0;
    req_unsigned_2 = '0;
    req_codigo = '0;
    saida_ready = 1'b0;
    test_reset();
    test_arith();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
